// File: rtl/sipo_ctrl_pkg.sv
// rtl/sipo_ctrl_pkg.sv - shared types and sizing helpers for the SIPO frame controller
package sipo_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    // Bit-counter width for a frame of 'width' bits; never narrower than 1.
    function automatic int cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/sipo_shift_en.sv
// rtl/sipo_shift_en.sv - WIDTH-bit serial-in/parallel-out shifter with enable and sync clear
//  clk       rising-edge clock
//  reset     asynchronous active-low reset, clears q
//  shift_en  shift din in at bit WIDTH-1, contents move toward bit 0
//  clear     synchronous clear, wins over shift_en
//  din       serial bit
//  q         parallel contents
module sipo_shift_en #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic             clear,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (shift_en) begin
            q <= {din, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// rtl/sipo_frame_ctrl.sv - frame controller for a SIPO shifter with valid/ready word hand-off
// Optional feature macro: SIPO_PARITY_EN (trailing even-parity bit per frame)
//  clk         rising-edge clock
//  reset       asynchronous active-low reset
//  start       1-cycle frame-start pulse
//  din         serial data bit, qualified by din_valid
//  din_valid   one bit accepted per cycle when high
//  out_ready   consumer accepts dout this cycle
//  dout        captured word, first received bit in dout[0]
//  dout_valid  dout holds an unconsumed word
//  busy        frame in progress
//  overrun     1-cycle pulse when a completed word is dropped
//  parity_err  parity result qualified by dout_valid (0 without SIPO_PARITY_EN)
module sipo_frame_ctrl
    import sipo_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             din,
    input  logic             din_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err
);

    localparam int CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] shift_q;

    logic             bit_ok;
    logic             last_data;
    logic             complete;
    logic             restart;
    logic             launch;
    logic             shift_en;
    logic             shift_clr;
    logic             accept;
    logic [WIDTH-1:0] word_nxt;

    assign bit_ok    = din_valid && (state != IDLE);
    assign last_data = bit_ok && (state == SHIFT) && (cnt == LAST_CNT);

`ifdef SIPO_PARITY_EN
    logic par_q;
    logic par_nxt;

    // Data is fully assembled when the parity bit arrives; the parity bit itself
    // only feeds the check.
    assign complete   = bit_ok && (state == PARITY);
    assign word_nxt   = shift_q;
    assign par_nxt    = ^{shift_q, din};
    assign parity_err = par_q;
`else
    // Completion happens on the edge that shifts in the last bit, so the word is
    // taken from the shifter's next value rather than its current contents.
    assign complete   = last_data;
    assign word_nxt   = shift_en ? {din, shift_q[WIDTH-1:1]} : shift_q;
    assign parity_err = 1'b0;
`endif

    // A completing bit beats a coincident start; otherwise start mid-frame restarts.
    assign restart   = start && (state != IDLE) && !complete;
    assign launch    = start && (state == IDLE);
    assign shift_clr = launch || restart;
    assign shift_en  = bit_ok && !restart;
    // A completed word is only taken if the output register is free or draining now.
    assign accept    = complete && !(dout_valid && !out_ready);

    sipo_shift_en #(
        .WIDTH(WIDTH)
    ) u_shift (
        .clk     (clk),
        .reset   (reset),
        .shift_en(shift_en),
        .clear   (shift_clr),
        .din     (din),
        .q       (shift_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            busy       <= 1'b0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= complete && dout_valid && !out_ready;

            if (accept) begin
                dout       <= word_nxt;
                dout_valid <= 1'b1;
            end else if (dout_valid && out_ready) begin
                dout_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SHIFT;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (restart) begin
                        cnt <= '0;
                    end else if (din_valid) begin
                        if (last_data) begin
                            cnt <= '0;
`ifdef SIPO_PARITY_EN
                            state <= PARITY;
`else
                            state <= IDLE;
                            busy  <= 1'b0;
`endif
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
`ifdef SIPO_PARITY_EN
                PARITY: begin
                    if (restart) begin
                        state <= SHIFT;
                        cnt   <= '0;
                    end else if (din_valid) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SIPO_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_q <= 1'b0;
        end else if (accept) begin
            par_q <= par_nxt;
        end
    end
`endif

endmodule
